// File: rtl/ipr_nvme_db_pkg.sv
// rtl/ipr_nvme_db_pkg.sv - shared types and constants for the NVMe doorbell writer
//
// Contents: FSM state enum, source index constants, doorbell register base
// offset, fixed AXI beat attributes and the source-to-doorbell index mapping.
package ipr_nvme_db_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } db_state_t;

    // Source indices, also the arbiter request bit positions
    localparam logic [1:0] SRC_SEQ  = 2'd0;
    localparam logic [1:0] SRC_ACQ  = 2'd1;
    localparam logic [1:0] SRC_IOSQ = 2'd2;
    localparam logic [1:0] SRC_IOCQ = 2'd3;

    // Doorbell registers start at BAR0 + 0x1000
    localparam logic [31:0] DB_BASE_OFFSET = 32'h1000;

    localparam logic [2:0] AXI_SIZE_4B   = 3'b010;
    localparam logic [3:0] AXI_STRB_ALL  = 4'hF;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Admin queue pair owns doorbells 0/1; the IO pair uses 2*qid / 2*qid+1
    function automatic logic [31:0] db_index(input logic [1:0] src, input int unsigned io_qid);
        logic [31:0] idx;
        case (src)
            SRC_SEQ:  idx = 32'd0;
            SRC_ACQ:  idx = 32'd1;
            SRC_IOSQ: idx = 32'(2 * io_qid);
            default:  idx = 32'(2 * io_qid + 1);
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/ipr_nvme_db_rr_arb.sv
// rtl/ipr_nvme_db_rr_arb.sv - 4-way round-robin arbiter for doorbell sources
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (pointer -> 0)
//   req[3:0]        request lines, bit = source index
//   update          accept the current grant; pointer moves to grant+1
//   grant[3:0]      one-hot grant (0 when no request)
//   grant_idx[1:0]  encoded grant
//   grant_valid     any request present
module ipr_nvme_db_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       update,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid
);

    logic [1:0] ptr;
    logic [1:0] cand;

    // Scan starting at the pointer; the first requester found wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr;
        cand        = ptr;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (update && grant_valid) begin
            ptr <= grant_idx + 2'd1;
        end
    end

endmodule

// File: rtl/ipr_nvme_db_axi.sv
// rtl/ipr_nvme_db_axi.sv - NVMe doorbell writer: arbitrates queue pointer updates into AXI4 writes
//
// Optional feature macro: IPR_NVME_DB_ERR_EN (response error flag and counter).
//
// Ports:
//   clk_in, resetb                       clock, synchronous active-high reset
//   seq/acq/iosq/iocq value + done       level requests from the queue FSMs
//   *_done_ack                           one-cycle capture pulse per granted request
//   dstrd                                CAP.DSTRD doorbell stride
//   db_aw*, db_w*, db_b*                 single-beat AXI4 write master
//   db_busy                              transaction in flight
//   db_write_cnt                         completed writes (wraps)
//   db_err, db_err_cnt                   sticky error / saturating error count
module ipr_nvme_db_axi
    import ipr_nvme_db_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          UNIQUE_ID_SZ = 3,
    parameter logic [31:0] BAR0_ADDR    = 32'ha000_0000,
    parameter int          IO_QID       = 1,
    parameter int          DB_AWID      = 0
) (
    input  logic                    clk_in,
    input  logic                    resetb,
    input  logic [15:0]             seq_tail_local,
    input  logic                    seq_tail_done,
    output logic                    seq_tail_done_ack,
    input  logic [15:0]             acq_head_local_out,
    input  logic                    acq_head_done,
    output logic                    acq_head_done_ack,
    input  logic [15:0]             iosq_tail_local,
    input  logic                    iosq_tail_done,
    output logic                    iosq_tail_done_ack,
    input  logic [15:0]             iocq_head_local_out,
    input  logic                    iocq_head_done,
    output logic                    iocq_head_done_ack,
    input  logic [3:0]              dstrd,
    output logic                    db_awvalid,
    input  logic                    db_awready,
    output logic [ADDR_WIDTH-1:0]   db_awaddr,
    output logic [7:0]              db_awlen,
    output logic [2:0]              db_awsize,
    output logic [UNIQUE_ID_SZ-1:0] db_awid,
    output logic                    db_wvalid,
    input  logic                    db_wready,
    output logic [31:0]             db_wdata,
    output logic [3:0]              db_wstrb,
    output logic                    db_wlast,
    input  logic                    db_bvalid,
    output logic                    db_bready,
    input  logic [1:0]              db_bresp,
    input  logic [UNIQUE_ID_SZ-1:0] db_bid,
    output logic                    db_busy,
    output logic [15:0]             db_write_cnt,
    output logic                    db_err,
    output logic [7:0]              db_err_cnt
);

    db_state_t   state, state_next;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic        grant_valid;
    logic        grant_take;
    logic [3:0]  ack_q;
    logic [15:0] sel_value;
    logic [31:0] addr_full;
    logic        aw_done;
    logic        w_done;
    logic        b_take;

    assign req = {iocq_head_done, iosq_tail_done, acq_head_done, seq_tail_done};

    ipr_nvme_db_rr_arb u_arb (
        .clk         (clk_in),
        .rst         (resetb),
        .req         (req),
        .update      (grant_take),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign grant_take = (state == ST_IDLE) && grant_valid;
    assign b_take     = (state == ST_RESP) && db_bvalid;

    // A channel counts as finished once its valid is low or is being accepted now
    assign aw_done = !db_awvalid || db_awready;
    assign w_done  = !db_wvalid  || db_wready;

    always_comb begin
        sel_value = seq_tail_local;
        case (grant_idx)
            SRC_SEQ:  sel_value = seq_tail_local;
            SRC_ACQ:  sel_value = acq_head_local_out;
            SRC_IOSQ: sel_value = iosq_tail_local;
            default:  sel_value = iocq_head_local_out;
        endcase
    end

    assign addr_full = BAR0_ADDR + DB_BASE_OFFSET
                     + (db_index(grant_idx, IO_QID) << (6'd2 + {2'b00, dstrd}));

    always_ff @(posedge clk_in) begin
        if (resetb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant_valid)       state_next = ST_ADDR;
            ST_ADDR: if (aw_done && w_done) state_next = ST_RESP;
            ST_RESP: if (db_bvalid)         state_next = ST_IDLE;
            default:                        state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (resetb) begin
            ack_q        <= 4'b0000;
            db_awvalid   <= 1'b0;
            db_wvalid    <= 1'b0;
            db_awaddr    <= '0;
            db_wdata     <= 32'h0;
            db_write_cnt <= 16'h0;
        end else begin
            ack_q <= 4'b0000;
            if (grant_take) begin
                ack_q      <= grant;
                db_awvalid <= 1'b1;
                db_wvalid  <= 1'b1;
                db_awaddr  <= ADDR_WIDTH'(addr_full);
                db_wdata   <= {16'h0, sel_value};
            end
            if (state == ST_ADDR) begin
                if (db_awvalid && db_awready) db_awvalid <= 1'b0;
                if (db_wvalid && db_wready)   db_wvalid  <= 1'b0;
            end
            if (b_take) begin
                db_write_cnt <= db_write_cnt + 16'd1;
            end
        end
    end

`ifdef IPR_NVME_DB_ERR_EN
    always_ff @(posedge clk_in) begin
        if (resetb) begin
            db_err     <= 1'b0;
            db_err_cnt <= 8'h00;
        end else if (b_take && (db_bresp != AXI_RESP_OKAY)) begin
            db_err <= 1'b1;
            if (db_err_cnt != 8'hFF) db_err_cnt <= db_err_cnt + 8'd1;
        end
    end

    logic unused_ok;
    assign unused_ok = ^db_bid;
`else
    assign db_err     = 1'b0;
    assign db_err_cnt = 8'h00;

    logic unused_ok;
    assign unused_ok = ^{db_bid, db_bresp};
`endif

    assign seq_tail_done_ack  = ack_q[SRC_SEQ];
    assign acq_head_done_ack  = ack_q[SRC_ACQ];
    assign iosq_tail_done_ack = ack_q[SRC_IOSQ];
    assign iocq_head_done_ack = ack_q[SRC_IOCQ];

    assign db_awlen  = 8'h00;
    assign db_awsize = AXI_SIZE_4B;
    assign db_awid   = UNIQUE_ID_SZ'(DB_AWID);
    assign db_wstrb  = AXI_STRB_ALL;
    assign db_wlast  = 1'b1;
    assign db_bready = (state == ST_RESP);
    assign db_busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_ipr_nvme_db_axi.sv
// tb/tb_ipr_nvme_db_axi.sv - self-checking bench for ipr_nvme_db_axi
module tb_ipr_nvme_db_axi;

    logic        clk_in = 1'b0;
    logic        resetb;
    logic        done [4];
    logic [15:0] val  [4];
    logic [3:0]  ack_w;
    logic [3:0]  dstrd;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [7:0]  awlen;
    logic [2:0]  awsize, awid, bid;
    logic [3:0]  wstrb;
    logic        wlast;
    logic [1:0]  bresp;
    logic        busy, err;
    logic [15:0] wcnt;
    logic [7:0]  err_cnt;

    always #5 clk_in = ~clk_in;

    ipr_nvme_db_axi dut (
        .clk_in(clk_in), .resetb(resetb),
        .seq_tail_local(val[0]),      .seq_tail_done(done[0]),  .seq_tail_done_ack(ack_w[0]),
        .acq_head_local_out(val[1]),  .acq_head_done(done[1]),  .acq_head_done_ack(ack_w[1]),
        .iosq_tail_local(val[2]),     .iosq_tail_done(done[2]), .iosq_tail_done_ack(ack_w[2]),
        .iocq_head_local_out(val[3]), .iocq_head_done(done[3]), .iocq_head_done_ack(ack_w[3]),
        .dstrd(dstrd),
        .db_awvalid(awvalid), .db_awready(awready), .db_awaddr(awaddr), .db_awlen(awlen),
        .db_awsize(awsize), .db_awid(awid),
        .db_wvalid(wvalid), .db_wready(wready), .db_wdata(wdata), .db_wstrb(wstrb), .db_wlast(wlast),
        .db_bvalid(bvalid), .db_bready(bready), .db_bresp(bresp), .db_bid(bid),
        .db_busy(busy), .db_write_cnt(wcnt), .db_err(err), .db_err_cnt(err_cnt)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          stall_cnt = 0;
    logic        b_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0, b_hold = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic        ack_seen [4];
    int          ack_cnt  [4];
    int          b_cnt = 0;
    logic [15:0] exp_wcnt = 16'd0;

    // AXI slave + scoreboard consumer; runs on the falling edge
    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 3'd0;
        forever begin
            @(negedge clk_in);
            if (resetb) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
                b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
            end else begin
                awready = (stall_cnt == 0);
                if (stall_cnt > 0) stall_cnt--;
                wready = 1'b1;
                bvalid = b_pend && !b_hold;
                bresp  = bvalid ? bresp_cfg : 2'b00;
                for (int s = 0; s < 4; s++) begin
                    if (ack_w[s]) begin
                        ack_cnt[s]++;
                        ack_seen[s] = 1'b1;
                    end
                end
                if (awvalid && awready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL aw_unexpected addr=%h", awaddr);
                    end else if (awaddr !== exp_q[0].addr) begin
                        errors++;
                        $display("FAIL aw_addr got=%h exp=%h", awaddr, exp_q[0].addr);
                    end
                    aw_got = 1'b1;
                end
                if (wvalid && wready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL w_unexpected data=%h", wdata);
                    end else if (wdata !== exp_q[0].data) begin
                        errors++;
                        $display("FAIL w_data got=%h exp=%h", wdata, exp_q[0].data);
                    end
                    w_got = 1'b1;
                end
                if (bvalid && bready) begin
                    b_cnt++;
                    b_pend = 1'b0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (aw_got && w_got) begin
                    b_pend = 1'b1;
                    aw_got = 1'b0;
                    w_got  = 1'b0;
                end
            end
        end
    end

    // Source model: drop done the cycle after its ack was seen
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            for (int s = 0; s < 4; s++) begin
                if (ack_seen[s]) begin
                    done[s]     = 1'b0;
                    ack_seen[s] = 1'b0;
                end
            end
        end
    end

    task automatic raise(input int s, input logic [15:0] v, input logic [31:0] addr);
        val[s]  = v;
        done[s] = 1'b1;
        exp_q.push_back('{addr, {16'h0, v}});
        exp_wcnt = exp_wcnt + 16'd1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(posedge clk_in);
            #2;
            n++;
        end while ((exp_q.size() != 0 || busy || done[0] || done[1] || done[2] || done[3]) && n < 400);
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d busy=%b", name, exp_q.size(), busy);
        end
        checks++;
        if (wcnt !== exp_wcnt) begin
            errors++;
            $display("FAIL %s_write_cnt got=%0d exp=%0d", name, wcnt, exp_wcnt);
        end
    endtask

    task automatic do_reset();
        @(posedge clk_in); #1;
        resetb = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        resetb = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk_in); #2;
        checks++;
        if ({awvalid, wvalid, bready, busy, err, ack_w} !== 9'b0 || awaddr !== 32'h0 || wdata !== 32'h0
            || wcnt !== 16'h0 || err_cnt !== 8'h0) begin
            errors++;
            $display("FAIL reset_zero got=%b addr=%h data=%h cnt=%0d ecnt=%0d",
                     {awvalid, wvalid, bready, busy, err, ack_w}, awaddr, wdata, wcnt, err_cnt);
        end
        checks++;
        if (awlen !== 8'h0 || awsize !== 3'b010 || wstrb !== 4'hF || wlast !== 1'b1 || awid !== 3'd0) begin
            errors++;
            $display("FAIL reset_const len=%h size=%b strb=%h last=%b id=%0d", awlen, awsize, wstrb, wlast, awid);
        end
    endtask

    task automatic test_single();
        int a0;
        dstrd = 4'd0;
        a0 = ack_cnt[0];
        @(posedge clk_in); #1;
        raise(0, 16'h0005, 32'ha000_1000);
        #1;
        checks++;
        if (ack_w[0] !== 1'b0 || awvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_n ack=%b awvalid=%b exp=0/0", ack_w[0], awvalid);
        end
        @(posedge clk_in); #2;
        checks++;
        if (ack_w[0] !== 1'b1 || awvalid !== 1'b1 || wvalid !== 1'b1
            || awaddr !== 32'ha000_1000 || wdata !== 32'h0000_0005) begin
            errors++;
            $display("FAIL single_n1 ack=%b aw=%b w=%b addr=%h data=%h",
                     ack_w[0], awvalid, wvalid, awaddr, wdata);
        end
        @(posedge clk_in); #2;
        checks++;
        if (ack_w[0] !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_n2 ack=%b aw=%b w=%b bready=%b busy=%b exp=0/0/0/1/1",
                     ack_w[0], awvalid, wvalid, bready, busy);
        end
        @(posedge clk_in); #2;
        checks++;
        if (busy !== 1'b0 || wcnt !== 16'd1) begin
            errors++;
            $display("FAIL single_n3 busy=%b cnt=%0d exp=0/1", busy, wcnt);
        end
        wait_idle("single");
        checks++;
        if (ack_cnt[0] - a0 != 1) begin
            errors++;
            $display("FAIL single_ack_pulses got=%0d exp=1", ack_cnt[0] - a0);
        end
    endtask

    task automatic test_dstrd();
        int a3;
        a3 = ack_cnt[3];
        @(posedge clk_in); #1;
        dstrd = 4'd2;
        raise(3, 16'h003f, 32'ha000_1030);
        wait_idle("dstrd");
        checks++;
        if (ack_cnt[3] - a3 != 1) begin
            errors++;
            $display("FAIL dstrd_ack_pulses got=%0d exp=1", ack_cnt[3] - a3);
        end
        dstrd = 4'd0;
    endtask

    task automatic test_round_robin();
        @(posedge clk_in); #1;
        resetb = 1'b1;
        exp_wcnt = 16'd0;
        exp_q.delete();
        raise(0, 16'h0010, 32'ha000_1000);
        raise(1, 16'h0021, 32'ha000_1004);
        raise(2, 16'h0032, 32'ha000_1008);
        raise(3, 16'h0043, 32'ha000_100C);
        repeat (2) @(posedge clk_in);
        #1;
        resetb = 1'b0;
        wait_idle("rr_round1");
        @(posedge clk_in); #1;
        raise(0, 16'h0110, 32'ha000_1000);
        raise(1, 16'h0121, 32'ha000_1004);
        raise(2, 16'h0132, 32'ha000_1008);
        raise(3, 16'h0143, 32'ha000_100C);
        wait_idle("rr_round2");
    endtask

    task automatic test_aw_stall();
        int b0;
        b0 = b_cnt;
        @(posedge clk_in); #1;
        stall_cnt = 10;
        raise(2, 16'h0077, 32'ha000_1008);
        @(posedge clk_in); #2;
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
            errors++;
            $display("FAIL stall_start aw=%b w=%b exp=1/1", awvalid, wvalid);
        end
        @(posedge clk_in); #2;
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b0 || bready !== 1'b0) begin
            errors++;
            $display("FAIL stall_wdrop aw=%b w=%b bready=%b exp=1/0/0", awvalid, wvalid, bready);
        end
        repeat (4) @(posedge clk_in);
        #2;
        checks++;
        if (awvalid !== 1'b1 || awaddr !== 32'ha000_1008) begin
            errors++;
            $display("FAIL stall_hold aw=%b addr=%h exp=1/a0001008", awvalid, awaddr);
        end
        wait_idle("stall");
        checks++;
        if (b_cnt - b0 != 1) begin
            errors++;
            $display("FAIL stall_bcount got=%0d exp=1", b_cnt - b0);
        end
    endtask

    task automatic test_error();
        logic       exp_err;
        logic [7:0] exp_ecnt;
`ifdef IPR_NVME_DB_ERR_EN
        exp_err = 1'b1; exp_ecnt = 8'd1;
`else
        exp_err = 1'b0; exp_ecnt = 8'd0;
`endif
        @(posedge clk_in); #2;
        checks++;
        if (err !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL err_before err=%b cnt=%0d exp=0/0", err, err_cnt);
        end
        #1;
        bresp_cfg = 2'b10;
        raise(1, 16'h0011, 32'ha000_1004);
        wait_idle("err");
        bresp_cfg = 2'b00;
        checks++;
        if (err !== exp_err || err_cnt !== exp_ecnt) begin
            errors++;
            $display("FAIL err_after err=%b cnt=%0d exp=%b/%0d", err, err_cnt, exp_err, exp_ecnt);
        end
    endtask

    task automatic test_reset_in_resp();
        int n = 0;
        @(posedge clk_in); #1;
        b_hold = 1'b1;
        raise(0, 16'h0007, 32'ha000_1000);
        do begin
            @(posedge clk_in); #2;
            n++;
        end while (!bready && n < 50);
        checks++;
        if (!bready) begin
            errors++;
            $display("FAIL rst_resp_reach bready=%b exp=1", bready);
        end
        @(posedge clk_in); #1;
        resetb = 1'b1;
        @(posedge clk_in); #2;
        checks++;
        if (busy !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0
            || wcnt !== 16'd0 || err !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_resp_clear busy=%b aw=%b w=%b bready=%b cnt=%0d err=%b ecnt=%0d",
                     busy, awvalid, wvalid, bready, wcnt, err, err_cnt);
        end
        #1;
        exp_q.delete();
        exp_wcnt = 16'd0;
        b_hold   = 1'b0;
        resetb   = 1'b0;
        raise(0, 16'h0009, 32'ha000_1000);
        wait_idle("rst_recover");
    endtask

    initial begin
        for (int s = 0; s < 4; s++) begin
            done[s] = 1'b0; val[s] = 16'h0; ack_seen[s] = 1'b0; ack_cnt[s] = 0;
        end
        dstrd  = 4'd0;
        resetb = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        resetb = 1'b0;
        test_reset();
        test_single();
        test_dstrd();
        test_round_robin();
        test_aw_stall();
        test_error();
        test_reset_in_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ipr_nvme_db_axi.md
# ipr_nvme_db_axi

Doorbell writer for the NVMe host IP. It consumes the four tail/head update handshakes produced by the NVMe IO command block: admin SQ tail, admin CQ head, IO SQ tail and IO CQ head. It arbitrates among them round-robin and issues one single-beat AXI4 write per update to the matching doorbell register in the SSD's BAR0 space. It sits between the queue state machines and the PCIe bridge AXI slave port.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width
- UNIQUE_ID_SZ, 3, AXI ID width
- BAR0_ADDR, 32'ha000_0000, AXI-side base of controller BAR0
- IO_QID, 1, IO queue pair ID (doorbell index 2·IO_QID / 2·IO_QID+1)
- DB_AWID, 0, constant AWID

Ports (one clock; reset is synchronous and active-high):
- clk_in  in  1  clock
- resetb  in  1  synchronous active-high reset
- seq_tail_local  in  16  admin SQ tail value
- seq_tail_done  in  1  admin SQ tail request (level)
- seq_tail_done_ack  out  1  capture pulse
- acq_head_local_out  in  16  admin CQ head value
- acq_head_done  in  1  request
- acq_head_done_ack  out  1  capture pulse
- iosq_tail_local  in  16  IO SQ tail value
- iosq_tail_done  in  1  request
- iosq_tail_done_ack  out  1  capture pulse
- iocq_head_local_out  in  16  IO CQ head value
- iocq_head_done  in  1  request
- iocq_head_done_ack  out  1  capture pulse
- dstrd  in  4  CAP.DSTRD, quasi-static
- db_awvalid/db_awready  out/in  1  AW handshake
- db_awaddr  out  ADDR_WIDTH  doorbell address
- db_awlen/db_awsize/db_awid  out  8/3/UNIQUE_ID_SZ  0 / 3'b010 / DB_AWID
- db_wvalid/db_wready  out/in  1  W handshake
- db_wdata  out  32  {16'h0, value}
- db_wstrb/db_wlast  out  4/1  4'hF / 1
- db_bvalid/db_bready  in/out  1  B handshake
- db_bresp  in  2  write response
- db_bid  in  UNIQUE_ID_SZ  ignored
- db_busy  out  1  state ≠ IDLE
- db_write_cnt  out  16  completed doorbell writes, wraps
- db_err  out  1  sticky response error
- db_err_cnt  out  8  error count, saturates at 8'hFF

## Operation
- Source index: seq=0, acq=1, iosq=2, iocq=3. Doorbell index: 0, 1, 2·IO_QID, 2·IO_QID+1.
- db_awaddr = BAR0_ADDR + 32'h1000 + (dbidx << (2+dstrd)), truncated to ADDR_WIDTH.
- States: IDLE → ADDR → RESP → IDLE.
- IDLE: if any done is high, the round-robin arbiter grants one. The block latches value and index, registers the ack pulse, and enters ADDR. Arbiter pointer moves to grant+1 mod 4.
- ADDR: awvalid and wvalid are asserted together. Each drops independently on its handshake. When both channels are done, go to RESP.
- RESP: bready=1. On bvalid, db_write_cnt increments, state returns to IDLE and bresp is evaluated (see Configuration).
- Source rule: hold done and value until ack; deassert done by the cycle after ack. A done still high in IDLE is a new request.

## Timing
- done sampled high in IDLE cycle N → ack high for exactly cycle N+1; awvalid/wvalid high from N+1.
- AW and W accepted in the same cycle N+1 → bready from N+2. Minimum 3 cycles per doorbell.
- After bvalid in cycle M, the block is in IDLE at M+1 and can grant at M+1.
- Valids never drop before their handshake. awaddr/wdata are stable while valid.
- Reset values: all outputs 0 except db_awlen=0, db_awsize=3'b010, db_wstrb=4'hF, db_wlast=1, db_awid=DB_AWID. State IDLE, pointer 0.
- Reset mid-transaction: next cycle all outputs take reset values and the transfer is abandoned. The interconnect must be reset with the block.

## Configuration
- IPR_NVME_DB_ERR_EN defined: bresp≠2'b00 sets db_err (cleared only by reset) and increments db_err_cnt, which saturates. No retry.
- IPR_NVME_DB_ERR_EN undefined: bresp is ignored, and db_err and db_err_cnt are tied to 0.

## Structure
- Package ipr_nvme_db_pkg holds:
  - the state enum
  - source index constants
  - DB_BASE_OFFSET=32'h1000
  - AXI constants: size 3'b010, strobe 4'hF, OKAY
- Sub-module ipr_nvme_db_rr_arb: 4-way round-robin arbiter with request/grant, one-hot plus index outputs, and a pointer update enable.

## Test plan
- seq_tail_done, value 16'h0005, dstrd 0 → one ack pulse; AW 0xa000_1000, wdata 0x0000_0005; db_write_cnt=1.
- iocq_head_done, value 16'h003f, IO_QID 1, dstrd 2 → awaddr 0xa000_1030, wdata 0x3f.
- All four requests held from reset → writes to 0x1000, 0x1004, 0x1008, 0x100C in that order. A second round after re-request restarts from seq.
- wready high, awready low for 10 cycles → wvalid drops after 1 cycle, awvalid held; exactly one B cycle and one count.
- bresp=2'b10 with the macro defined → db_err=1, db_err_cnt=1. Without the macro, both stay 0.
- resetb asserted in RESP → the next cycle has db_busy=0, all valids 0, and counters cleared.
